mux_sel_arbiter: RTL and testbench

Two-requester round-robin arbiter that generates the `sel` control for the `mux2_1` 2:1 selector directly downstream. Each data source (`in1`, `in2` side) raises a request. The block grants one source at a time, holds the grant until release or timeout, and drives `sel` so the mux forwards the granted source. A mandatory idle cycle between grants guarantees `sel` never changes while a grant is active.

---
 rtl/mux_sel_arbiter_if.sv | 48 ++++
 rtl/mux_sel_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_sel_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between two mux sources and the select arbiter.
// Latency: none; this is wiring only.
// Backpressure: sources keep reqx high until granted; there is no other stall path.
interface mux_sel_arbiter_if #(
    parameter int CNT_W = 5
) ();
    // Source-driven request and release strobes
    logic             req1;
    logic             req2;
    logic             rel1;
    logic             rel2;

    // Arbiter-driven grant, mux select and status
    logic             gnt1;
    logic             gnt2;
    logic             sel;
    logic             busy;
    logic             timeout;
    logic [CNT_W-1:0] hold_cnt;

    // Requester side: raises requests/releases, observes grants
    modport master (
        output req1,
        output req2,
        output rel1,
        output rel2,
        input  gnt1,
        input  gnt2,
        input  sel,
        input  busy,
        input  timeout,
        input  hold_cnt
    );

    // Arbiter side: samples requests/releases, drives grants and sel
    modport slave (
        input  req1,
        input  req2,
        input  rel1,
        input  rel2,
        output gnt1,
        output gnt2,
        output sel,
        output busy,
        output timeout,
        output hold_cnt
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for two sources feeding a 2:1 mux; drives the mux sel directly.
// Latency: request sampled in IDLE -> grant/sel registered one edge later; release -> grant drops one edge later.
// Backpressure: a losing source simply keeps its request high; grants are capped at MAX_HOLD cycles.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    mux_sel_arbiter_if.slave  arb
);

    // Last value the hold counter may reach before a grant is forced off.
    // MAX_HOLD <= 2**CNT_W keeps this within CNT_W bits, so the counter never wraps.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             sel_q;
    logic             sel_d;
    logic             lst_q;      // 0: source 1 served last, 1: source 2 served last
    logic             lst_d;
    logic             timeout_q;
    logic             timeout_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic             gnt1_q;
    logic             gnt2_q;
    logic             busy_q;

    // Next-state, next-select and hold counter; every field defaulted first
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        lst_d     = lst_q;
        timeout_d = 1'b0;
        hold_d    = '0;

        unique case (state_q)
            IDLE: begin
                // Tie goes to whichever source was not served last
                if (arb.req1 && (!arb.req2 || lst_q)) begin
                    state_d = G1;
                    sel_d   = 1'b0;
                    lst_d   = 1'b0;
                end else if (arb.req2) begin
                    state_d = G2;
                    sel_d   = 1'b1;
                    lst_d   = 1'b1;
                end
            end

            G1: begin
                // A release always beats a coincident timeout
                if (arb.rel1 || !arb.req1) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            G2: begin
                if (arb.rel2 || !arb.req2) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; grants are decoded from the next state so they
    // appear in the same cycle the FSM enters Gx and never go straight G1<->G2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            lst_q     <= 1'b1;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            gnt1_q    <= 1'b0;
            gnt2_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lst_q     <= lst_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            gnt1_q    <= (state_d == G1);
            gnt2_q    <= (state_d == G2);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign arb.gnt1     = gnt1_q;
    assign arb.gnt2     = gnt2_q;
    assign arb.sel      = sel_q;
    assign arb.busy     = busy_q;
    assign arb.timeout  = timeout_q;
    assign arb.hold_cnt = hold_q;

    // The two grants are mutually exclusive
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        !(arb.gnt1 && arb.gnt2));

    // The mux selection is frozen for the whole life of a grant
    a_sel_stable: assert property (@(posedge clk) disable iff (rst)
        (arb.busy && $past(arb.busy)) |-> (arb.sel == $past(arb.sel)));

    // A forced release is only ever reported from an idle cycle
    a_timeout_idle: assert property (@(posedge clk) disable iff (rst)
        arb.timeout |-> !arb.busy);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with MAX_HOLD=4 and a queue-based scoreboard.
// Latency: each vector lists the outputs expected in the cycle it is applied.
// Backpressure: not applicable; the monitor drains expectations at fixed sample points.
module tb_mux_sel_arbiter;

    localparam int CNT_W = 5;

    typedef struct packed {
        int unsigned      id;
        logic             g1;
        logic             g2;
        logic             sel;
        logic             busy;
        logic             to;
        logic [CNT_W-1:0] hc;
    } exp_t;

    logic clk;
    logic rst;

    mux_sel_arbiter_if #(.CNT_W(CNT_W)) ifc ();

    mux_sel_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (ifc)
    );

    exp_t q_main[$];
    exp_t q_mid[$];
    int   checks;
    int   errors;
    int   row_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every output field against one expectation
    task automatic check(input exp_t e, input string tag);
        checks++;
        if ({ifc.gnt1, ifc.gnt2, ifc.sel, ifc.busy, ifc.timeout, ifc.hold_cnt} !==
            {e.g1, e.g2, e.sel, e.busy, e.to, e.hc}) begin
            errors++;
            $display("FAIL %s row %0d: got gnt1=%b gnt2=%b sel=%b busy=%b timeout=%b hold_cnt=%0d, want gnt1=%b gnt2=%b sel=%b busy=%b timeout=%b hold_cnt=%0d",
                     tag, e.id, ifc.gnt1, ifc.gnt2, ifc.sel, ifc.busy, ifc.timeout, ifc.hold_cnt,
                     e.g1, e.g2, e.sel, e.busy, e.to, e.hc);
        end
    endtask

    // Monitor: samples 3 time units after each edge, and again just before the next
    // edge for expectations queued by a mid-cycle asynchronous reset
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                check(e, "cycle");
            end
            #5;
            if (q_mid.size() > 0) begin
                e = q_mid.pop_front();
                check(e, "async_rst");
            end
        end
    end

    // Apply one vector just after an edge and queue the outputs expected in that cycle.
    // mid=1 additionally raises rst between edges and expects reset values before the next edge.
    task automatic step(input logic r, input logic mid,
                        input logic q1, input logic q2, input logic l1, input logic l2,
                        input logic g1, input logic g2, input logic s, input logic b,
                        input logic to, input int hc);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        ifc.req1 = q1;
        ifc.req2 = q2;
        ifc.rel1 = l1;
        ifc.rel2 = l2;
        e.id   = row_n;
        e.g1   = g1;
        e.g2   = g2;
        e.sel  = s;
        e.busy = b;
        e.to   = to;
        e.hc   = CNT_W'(hc);
        q_main.push_back(e);
        if (mid) begin
            #5;
            rst = 1'b1;
            e = '0;
            e.id = row_n;
            q_mid.push_back(e);
        end
        row_n++;
    endtask

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        row_n    = 0;
        rst      = 1'b1;
        ifc.req1 = 1'b0;
        ifc.req2 = 1'b0;
        ifc.rel1 = 1'b0;
        ifc.rel2 = 1'b0;

        //    rst mid r1 r2 l1 l2   g1 g2 sel busy to hc
        // Reset held with both requests up
        step(1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // Single request; release lands with hold_cnt=3 so release beats timeout
        step(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 0, 2);
        step(0, 0, 1, 0, 1, 0,   1, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // Tie round-robin: source 1 served last, so G2, IDLE, G1, IDLE, G2
        step(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 1);
        step(0, 0, 1, 1, 0, 1,   0, 1, 1, 1, 0, 2);
        step(0, 0, 1, 1, 0, 0,   0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1, 0,   1, 0, 0, 1, 0, 2);
        step(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 0);
        // Dropping the request ends the grant; sel holds through IDLE
        step(0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // Timeout: 4 grant cycles, timeout pulse in IDLE, then re-grant
        step(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 2);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 3);
        step(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 2);
        // Force-released source 2 still requesting loses the tie to source 1
        step(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 3);
        step(0, 0, 1, 1, 0, 0,   0, 0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1, 0,   1, 0, 0, 1, 0, 2);
        step(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0,   0, 1, 1, 1, 0, 1);
        // Asynchronous reset between edges while gnt2=1, hold_cnt=2
        step(0, 1, 1, 1, 0, 0,   0, 1, 1, 1, 0, 2);
        step(1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        // First grant after reset goes to source 1
        step(0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded in cycles
        for (int i = 0; i < 10 && (q_main.size() > 0 || q_mid.size() > 0); i++) begin
            @(posedge clk);
        end
        #9;
        if (q_main.size() > 0 || q_mid.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left, want 0", q_main.size() + q_mid.size());
        end
        if (checks != row_n + 1) begin
            errors++;
            $display("FAIL check_count: got %0d comparisons, want %0d", checks, row_n + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
